miner_nonce_dispatch: RTL and testbench

- Job-level controller that sequences the nonce range for the mining cores.
- Steps a base nonce by CORES per issue (core i tests base+i) and hands bases to the hash pipeline over a valid/ready handshake.
- Tracks in-flight bases, captures the first winning nonce, stops issuing, drains the pipeline, then reports found or exhausted.
- Sits between the job loader (start, range) and the CORES-wide hash pipeline.

---
 rtl/miner_nonce_dispatch.sv | 202 ++++++++++++++++++++
 tb/tb_miner_nonce_dispatch.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_nonce_dispatch.sv
// miner_nonce_dispatch: job-level nonce sequencer for the hash pipeline.
// Steps a base nonce by CORES per issue, limits in-flight bases, captures the
// first winning nonce, drains outstanding results and reports the job outcome.
// Optional build macro MINER_DISPATCH_PERF_EN adds the o_hashes_done counter.
module miner_nonce_dispatch #(
    parameter int unsigned CORES        = 1,
    parameter int unsigned NONCE_BITS   = 32,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [NONCE_BITS-1:0] i_nonce_start,
    input  logic [NONCE_BITS-1:0] i_nonce_end,
    output logic                  o_issue_valid,
    input  logic                  i_issue_ready,
    output logic [NONCE_BITS-1:0] o_issue_nonce,
    input  logic                  i_res_valid,
    input  logic [NONCE_BITS-1:0] i_res_base,
    input  logic [CORES-1:0]      i_res_hit_mask,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_found,
    output logic [NONCE_BITS-1:0] o_found_nonce,
    output logic                  o_aborted
`ifdef MINER_DISPATCH_PERF_EN
    ,
    output logic [NONCE_BITS+8-1:0] o_hashes_done
`endif
);

    localparam int unsigned OUT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned SUM_W = NONCE_BITS + 2;
    localparam int unsigned IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NONCE_BITS-1:0] r_counter;
    logic [NONCE_BITS-1:0] r_end;
    logic [OUT_W-1:0]      r_outstanding;
    logic [OUT_W-1:0]      w_out_nxt;
    logic                  r_found;
    logic [NONCE_BITS-1:0] r_found_nonce;
    logic                  r_aborted;

    logic                  w_active;
    logic                  w_start_ok;
    logic                  w_issue_fire;
    logic                  w_res_take;
    logic                  w_hit;
    logic [SUM_W-1:0]      w_step;
    logic                  w_last;
    logic [IDX_W-1:0]      w_hit_idx;
    logic [NONCE_BITS-1:0] w_hit_nonce;

    assign w_active   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_start_ok = (r_state == S_IDLE) && i_start;

    assign o_issue_valid = (r_state == S_ISSUE) &&
                           (r_outstanding < OUT_W'(MAX_INFLIGHT)) &&
                           !r_found && !i_abort;
    assign o_issue_nonce = r_counter;
    assign w_issue_fire  = o_issue_valid && i_issue_ready;

    // Results only count against bases this job still has outstanding.
    assign w_res_take = w_active && i_res_valid && (r_outstanding != '0);
    assign w_hit      = w_res_take && (|i_res_hit_mask) && !r_found &&
                        !r_aborted && !i_abort;

    // Two extra bits keep base+CORES-1 and the 2^NONCE_BITS overflow exact.
    assign w_step = SUM_W'(r_counter) + SUM_W'(CORES);
    assign w_last = ((w_step - SUM_W'(1)) >= SUM_W'(r_end)) ||
                    (w_step > (SUM_W'(1) << NONCE_BITS));

    // Lowest set bit of the hit mask selects the winning core.
    always_comb begin
        w_hit_idx = '0;
        for (int unsigned i = CORES; i > 0; i--) begin
            if (i_res_hit_mask[i-1]) begin
                w_hit_idx = IDX_W'(i - 1);
            end
        end
    end

    assign w_hit_nonce = i_res_base + NONCE_BITS'(w_hit_idx);

    // Outstanding count: issue and result on the same edge cancel out.
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_issue_fire && !w_res_take) begin
            w_out_nxt = r_outstanding + OUT_W'(1);
        end else if (!w_issue_fire && w_res_take) begin
            w_out_nxt = r_outstanding - OUT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_busy = 1'b1;
                if (i_abort || w_hit || (w_issue_fire && w_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (w_out_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job datapath: range, counter, outstanding and outcome flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter     <= '0;
            r_end         <= '0;
            r_outstanding <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_aborted     <= 1'b0;
        end else if (w_start_ok) begin
            r_counter     <= i_nonce_start;
            r_end         <= i_nonce_end;
            r_outstanding <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_aborted     <= 1'b0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_issue_fire && !w_last) begin
                r_counter <= r_counter + NONCE_BITS'(CORES);
            end
            if (w_hit) begin
                r_found       <= 1'b1;
                r_found_nonce <= w_hit_nonce;
            end
            if (w_active && i_abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign o_found       = r_found;
    assign o_found_nonce = r_found_nonce;
    assign o_aborted     = r_aborted;

`ifdef MINER_DISPATCH_PERF_EN
    localparam int unsigned HD_W = NONCE_BITS + 8;

    logic [HD_W-1:0] r_hashes_done;
    logic [HD_W:0]   w_hashes_sum;

    assign w_hashes_sum = {1'b0, r_hashes_done} + (HD_W + 1)'(CORES);

    // Saturating count of hashes whose results came back for this job.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_hashes_done <= '0;
        end else if (w_res_take) begin
            r_hashes_done <= w_hashes_sum[HD_W] ? '1 : w_hashes_sum[HD_W-1:0];
        end
    end

    assign o_hashes_done = r_hashes_done;
`endif

endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// Bench for miner_nonce_dispatch (CORES=4, NONCE_BITS=8, MAX_INFLIGHT=4).
// A pipeline responder returns issued bases after random delays; a monitor
// keeps a job-level reference model and scores every cycle.
module tb_miner_nonce_dispatch;
    localparam int unsigned CORES = 4;
    localparam int unsigned NB    = 8;
    localparam int unsigned MAXF  = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, ir, rv;
    logic [NB-1:0] ns, ne, rb;
    logic [3:0]    rm;
    logic          iv, busy, done, found, aborted;
    logic [NB-1:0] inonce, fn;
`ifdef MINER_DISPATCH_PERF_EN
    logic [NB+8-1:0] hd;
`endif

    miner_nonce_dispatch #(
        .CORES(CORES),
        .NONCE_BITS(NB),
        .MAX_INFLIGHT(MAXF)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_abort(abort),
        .i_nonce_start(ns),
        .i_nonce_end(ne),
        .o_issue_valid(iv),
        .i_issue_ready(ir),
        .o_issue_nonce(inonce),
        .i_res_valid(rv),
        .i_res_base(rb),
        .i_res_hit_mask(rm),
        .o_busy(busy),
        .o_done(done),
        .o_found(found),
        .o_found_nonce(fn),
        .o_aborted(aborted)
`ifdef MINER_DISPATCH_PERF_EN
        ,
        .o_hashes_done(hd)
`endif
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_hs   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- pipeline responder ----------------
    typedef struct {
        logic [NB-1:0] base;
        int            due;
    } pend_t;

    pend_t         pipe[$];
    bit            hold_res = 1'b0;
    int            res_prob = 100;
    bit            h1_en = 1'b0, h2_en = 1'b0;
    logic [NB-1:0] h1_base = '0, h2_base = '0;
    logic [3:0]    h1_mask = '0, h2_mask = '0;

    function automatic logic [3:0] mask_for(input logic [NB-1:0] b);
        if (h1_en && b == h1_base) return h1_mask;
        if (h2_en && b == h2_base) return h2_mask;
        return 4'd0;
    endfunction

    initial forever begin
        @(negedge clk);
        if (iv && ir && !rst) begin
            pipe.push_back('{inonce, cyc + int'($urandom_range(1, 4))});
            n_hs++;
        end
    end

    initial begin
        rv = 1'b0;
        rb = '0;
        rm = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!hold_res && pipe.size() > 0 && pipe[0].due <= cyc &&
                int'($urandom_range(0, 99)) < res_prob) begin
                rv = 1'b1;
                rb = pipe[0].base;
                rm = mask_for(pipe[0].base);
                void'(pipe.pop_front());
            end else begin
                rv = 1'b0;
                rb = NB'($urandom);
                rm = 4'($urandom);
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    typedef enum {P_IDLE, P_ISSUE, P_DRAIN, P_DONE} ph_t;

    logic [NB-1:0] q_exp[$];

    initial begin
        ph_t           ph;
        int            m_out;
        bit            m_found, m_ab, just_rst, exp_iv, fire, take, hit_now, range_done;
        logic [NB-1:0] m_fn, e;
        logic [3:0]    low;
        logic [15:0]   m_hashes;
        ph = P_IDLE; m_out = 0; m_found = 0; m_ab = 0; m_fn = '0; m_hashes = '0;
        just_rst = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = P_IDLE; m_out = 0; m_found = 0; m_ab = 0; m_fn = '0; m_hashes = '0;
                q_exp.delete();
                just_rst = 1;
            end else begin
                exp_iv = (ph == P_ISSUE) && (m_out < int'(MAXF)) && !m_found && !abort;
                chk("issue_valid", 32'(iv), 32'(exp_iv));
                chk("busy", 32'(busy), 32'(ph == P_ISSUE || ph == P_DRAIN));
                chk("done", 32'(done), 32'(ph == P_DONE));
                chk("found", 32'(found), 32'(m_found));
                chk("found_nonce", 32'(fn), 32'(m_fn));
                chk("aborted", 32'(aborted), 32'(m_ab));
`ifdef MINER_DISPATCH_PERF_EN
                chk("hashes_done", 32'(hd), 32'(m_hashes));
`endif
                if (just_rst) chk("issue_nonce_after_reset", 32'(inonce), 32'd0);
                just_rst = 0;
                fire = exp_iv && ir;
                take = rv && (m_out > 0) && (ph == P_ISSUE || ph == P_DRAIN);
                case (ph)
                    P_IDLE: begin
                        if (start) begin
                            ph = P_ISSUE; m_out = 0; m_found = 0; m_ab = 0;
                            m_fn = '0; m_hashes = '0;
                        end
                    end
                    P_ISSUE, P_DRAIN: begin
                        range_done = 0;
                        hit_now    = 0;
                        if (fire) begin
                            if (q_exp.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL issue_beyond_range: got base 0x%0h expected no issue (cycle %0d)", inonce, cyc);
                            end else begin
                                e = q_exp.pop_front();
                                chk("issue_nonce", 32'(inonce), 32'(e));
                                range_done = (q_exp.size() == 0);
                            end
                            m_out++;
                        end
                        if (take) begin
                            m_out--;
                            m_hashes = m_hashes + 16'(CORES);
                            if (rm != 0 && !m_found && !m_ab && !abort) begin
                                low     = rm & (~rm + 4'd1);
                                m_found = 1;
                                m_fn    = rb + NB'($clog2(low));
                                hit_now = 1;
                            end
                        end
                        if (abort) m_ab = 1;
                        if (ph == P_ISSUE) begin
                            if (abort || hit_now || range_done) ph = P_DRAIN;
                        end else if (m_out == 0) begin
                            ph = P_DONE;
                        end
                    end
                    P_DONE: begin
                        if (!m_found && !m_ab) chk("bases_left_unissued", 32'(q_exp.size()), 32'd0);
                        q_exp.delete();
                        ph = P_IDLE;
                    end
                    default: ph = P_IDLE;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 3000) begin
            tick();
            k++;
        end
    endtask

    task automatic run_job(input logic [NB-1:0] s, input logic [NB-1:0] e, input int rdy_pct,
                           input int abort_at, input int hold_n, input int rdy_stop,
                           input int glitch_at, input bit check_cap);
        longint b;
        bit     seen;
        int     hs0;
        wait_idle();
        // Expected bases straight from the range rules, in unbounded arithmetic.
        b = longint'(s);
        forever begin
            q_exp.push_back(NB'(b));
            if (b + CORES - 1 >= longint'(e) || b + CORES > 256) break;
            b += CORES;
        end
        hs0   = n_hs;
        start = 1'b1; ns = s; ne = e;
        tick();
        start = 1'b0; ns = NB'($urandom); ne = NB'($urandom);
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (check_cap && k == 10) chk("inflight_cap_handshakes", 32'(n_hs - hs0), 32'(MAXF));
            hold_res = (k < hold_n);
            ir       = (rdy_stop >= 0 && k >= rdy_stop) ? 1'b0 :
                       (int'($urandom_range(0, 99)) < rdy_pct);
            abort    = (k == abort_at);
            if (k == glitch_at) begin
                start = 1'b1; ns = NB'($urandom); ne = NB'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) seen = 1;
        end
        ir = 1'b0; abort = 1'b0; start = 1'b0; hold_res = 1'b0;
        chk("job_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] s, e;
        int            mode;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ir = 1'b0; ns = '0; ne = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // abort while idle is ignored
        abort = 1'b1; tick(); abort = 1'b0; tick();

        // small range, no hits: bases 0, 4
        run_job(8'd0, 8'd5, 100, -1, 0, -1, -1, 0);
        chk("t1_found", 32'(found), 32'd0);
        chk("t1_aborted", 32'(aborted), 32'd0);

        // 8..20 -> 8,12,16,20 ; 8..18 -> 8,12,16
        run_job(8'd8, 8'd20, 100, -1, 0, -1, -1, 0);
        run_job(8'd8, 8'd18, 70, -1, 0, -1, -1, 0);
        chk("t2_found", 32'(found), 32'd0);

        // hit at base 12 mask 0110 -> 13; later hit at base 16 ignored
        h1_en = 1; h1_base = 8'd12; h1_mask = 4'b0110;
        h2_en = 1; h2_base = 8'd16; h2_mask = 4'b0001;
        run_job(8'd0, 8'd100, 100, -1, 0, -1, -1, 0);
        chk("t3_found", 32'(found), 32'd1);
        chk("t3_found_nonce", 32'(fn), 32'd13);
        h1_en = 0; h2_en = 0;

        // in-flight cap: results withheld, exactly MAXF handshakes
        run_job(8'd0, 8'd100, 100, -1, 12, -1, -1, 1);

        // abort with two bases outstanding; second result carries a hit
        h1_en = 1; h1_base = 8'd4; h1_mask = 4'b0001;
        run_job(8'd0, 8'd100, 100, 4, 6, 2, -1, 0);
        chk("t5_aborted", 32'(aborted), 32'd1);
        chk("t5_found", 32'(found), 32'd0);
        h1_en = 0;

        // top of nonce space, start>end, single-nonce range
        run_job(8'hF8, 8'hFF, 100, -1, 0, -1, -1, 0);
        run_job(8'hFC, 8'h05, 100, -1, 0, -1, -1, 0);
        run_job(8'hFF, 8'hFF, 100, -1, 0, -1, -1, 0);

        // reset while draining, then stale results reach an idle block
        wait_idle();
        res_prob = 100;
        hold_res = 1'b1;
        q_exp.push_back(8'd0);
        q_exp.push_back(8'd4);
        start = 1'b1; ns = 8'd0; ne = 8'd7; ir = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        ir = 1'b0;
        chk("drain_busy_before_reset", 32'(busy), 32'd1);
        chk("drain_no_issue", 32'(iv), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        hold_res = 1'b0;
        repeat (12) tick();
        chk("stale_results_pipe_empty", 32'(pipe.size()), 32'd0);

        // randomized jobs
        repeat (25) begin
            s    = NB'($urandom);
            mode = int'($urandom_range(0, 3));
            case (mode)
                0, 1:    e = NB'(s + NB'($urandom_range(0, 30)));
                2:       e = NB'($urandom);
                default: e = NB'(s - NB'($urandom_range(1, 5)));
            endcase
            h1_en    = $urandom_range(0, 1);
            h1_base  = NB'(s + NB'(4 * $urandom_range(0, 6)));
            h1_mask  = 4'($urandom_range(1, 15));
            h2_en    = $urandom_range(0, 1);
            h2_base  = NB'(s + NB'(4 * $urandom_range(0, 8)));
            h2_mask  = 4'($urandom_range(1, 15));
            res_prob = int'($urandom_range(30, 100));
            run_job(s, e, int'($urandom_range(30, 100)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
                    0, -1,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : -1, 0);
            if ($urandom_range(0, 5) == 0) begin
                wait_idle();
                abort = 1'b1; tick(); abort = 1'b0;
            end
        end
        wait_idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
